mul_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers; successor to the single-cycle ALU for MULT/MULTU/DIV/DIVU/MTHI/MTLO support.
- Sits beside the ALU in the datapath. The controller issues `start` and stalls the PC while `busy` is high; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/mul_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MDU_FAST_MUL_EN to compute products in a single combinational step instead of iterating.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 res_neg_q, res_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 div_zero_q, div_zero_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 accept;
  logic                 is_div;
  logic                 is_signed;
  logic                 b_zero;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // The done cycle is still IDLE, but a start seen there waits one more cycle.
  assign accept    = (state_q == S_IDLE) && start && !done_q;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);

  // Two's complement magnitude; MIN maps to itself and is then read as unsigned.
  assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
  assign div_step  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = res_neg_q ? -acc_q : acc_q;
  assign quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_PREP;
      S_PREP: begin
        if (is_div && b_zero) begin
          state_d = S_FIN;
        end else begin
`ifdef MDU_FAST_MUL_EN
          state_d = is_div ? S_RUN : S_FIN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN:  if (cnt_q == CW'(1)) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = op;
          a_d        = a;
          b_d        = b;
          div_zero_d = 1'b0;
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_PREP: begin
        m_d       = is_div ? mag_b : mag_a;
        acc_d     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        cnt_d     = CW'(WIDTH);
        res_neg_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rem_neg_d = is_signed && a_q[WIDTH-1];
`ifdef MDU_FAST_MUL_EN
        if (!is_div) acc_d = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = is_div ? div_step : mul_step;
      end
      S_FIN: begin
        done_d = 1'b1;
        if (!is_div) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_zero) begin
          hi_d       = a_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/div_zero per operation are queued at issue
// and compared by an independent monitor whenever done pulses.
module tb_mul_div_unit;

  localparam int W = 32;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_EDGES = 2;
`else
  localparam int MUL_EDGES = W + 2;
`endif

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [W-1:0] model_hi, model_lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the architectural definition, using 64-bit integer arithmetic.
  function automatic exp_t model(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint sx, sy, q, m;
    logic [63:0] t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r.dz = 1'b0;
    case (f)
      2'b00: begin t = 64'(sx * sy); r.hi = t[63:32]; r.lo = t[31:0]; end
      2'b01: begin t = {32'b0, x} * {32'b0, y}; r.hi = t[63:32]; r.lo = t[31:0]; end
      default: begin
        if (y == 0) begin
          r.hi = x; r.lo = '1; r.dz = 1'b1;
        end else if (f == 2'b10) begin
          q = sx / sy; m = sx % sy;
          t = 64'(q); r.lo = t[31:0];
          t = 64'(m); r.hi = t[31:0];
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          check("result_hi", 64'(hi), 64'(e.hi));
          check("result_lo", 64'(lo), 64'(e.lo));
          check("result_div_zero", 64'(div_zero), 64'(e.dz));
        end
      end
    end
  end

  function automatic int edges_for(input logic [1:0] f, input logic [W-1:0] y);
    if (f[1] && y == 0) return 2;
    if (!f[1]) return MUL_EDGES;
    return W + 2;
  endfunction

  // Issue one op; optionally with MTHI/MTLO in the same cycle (must be dropped).
  task automatic run_op(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit with_we);
    exp_t e;
    int   edges, busy_cnt, exp_edges;
    bit   seen;
    logic [W-1:0] prev_hi, prev_lo;
    prev_hi = model_hi;
    prev_lo = model_lo;
    e = model(f, x, y);
    exp_edges = edges_for(f, y);
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    op = f; a = x; b = y; start = 1'b1;
    hi_we = with_we; lo_we = with_we; wdata = $urandom;
    if (done) begin
      @(posedge clk); #1;
      check("start_in_done_ignored", 64'(busy), 64'(0));
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    if (with_we) begin
      check("we_with_start_hi", 64'(hi), 64'(prev_hi));
      check("we_with_start_lo", 64'(lo), 64'(prev_lo));
    end
    check("div_zero_cleared", 64'(div_zero), 64'(0));
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); edges++; #1;
      if (edges == 1) begin start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
      if (edges == 2) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
      if (busy) busy_cnt++;
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("done_seen", 64'(seen), 64'(1));
    check("latency_edges", 64'(edges), 64'(exp_edges));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_edges));
  endtask

  task automatic mt_write(input bit hw, input bit lw, input logic [W-1:0] d);
    while (done) begin @(posedge clk); #1; end
    hi_we = hw; lo_we = lw; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) model_hi = d;
    if (lw) model_lo = d;
    check("mt_hi", 64'(hi), 64'(model_hi));
    check("mt_lo", 64'(lo), 64'(model_lo));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin : stim
    logic [W-1:0] y;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_div_zero", 64'(div_zero), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'h1234_5678, 32'd0, 1'b0);
    check("div_zero_sticky", 64'(div_zero), 64'(1));
    run_op(2'b01, 32'd3, 32'd4, 1'b1);

    mt_write(1'b0, 1'b1, 32'hA5A5_A5A5);
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    mt_write(1'b0, 1'b1, 32'hA5A5_A5A5);

`ifdef MDU_FAST_MUL_EN
    run_op(2'b00, 32'd5, 32'd6, 1'b0);
    check("fast_mul_lo", 64'(model_lo), 64'(30));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
`else
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (k == 4) begin
        start = 1'b0; hi_we = 1'b0;
        check("midrun_busy", 64'(busy), 64'(1));
        check("midrun_hi_kept", 64'(hi), 64'(model_hi));
        check("midrun_lo_kept", 64'(lo), 64'(model_lo));
      end
      if (k == 10) rst = 1'b1;
    end
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
`endif

    for (int n = 0; n < 40; n++) begin
      y = ($urandom_range(7) == 0) ? 32'h0 : pick();
      run_op(2'($urandom), pick(), y, 1'($urandom_range(1)));
    end

    @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
